// File: rtl/pc_shot_engine.sv
// Computer-opponent shot engine: waits out a think delay, picks an unshot player cell
// (LFSR + linear probe), scores it against the latched fleet. Optional hunt mode: PC_HUNT_EN.
module pc_shot_engine #(
    parameter int          BOARD_N      = 5,
    parameter int          THINK_CYCLES = 16,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5,
    localparam int         CELLS        = BOARD_N * BOARD_N,
    localparam int         IDX_W        = $clog2(CELLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             setup_State,
    input  logic             pc_turn_State,
    input  logic [CELLS-1:0] player_board,
    output logic             pc_has_move,
    output logic             player_ships_zero,
    output logic [CELLS-1:0] shot_map,
    output logic [CELLS-1:0] hit_map,
    output logic [IDX_W-1:0] last_idx,
    output logic             last_hit
);

    localparam int CNT_W = (THINK_CYCLES > 1) ? $clog2(THINK_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, THINK, PICK, FIRE, DONE} state_t;

    state_t           state;
    logic [CELLS-1:0] occ;
    logic [IDX_W:0]   remaining;
    logic             loaded;
    logic [7:0]       lfsr;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] lfsr_cand;
    logic [IDX_W-1:0] pick_cand;

    assign lfsr_cand         = IDX_W'(32'(lfsr) % CELLS);
    assign player_ships_zero = loaded && (remaining == '0);

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1; free-running so the pick depends on turn timing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            lfsr <= LFSR_SEED;
        else
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

`ifdef PC_HUNT_EN
    logic             hunt;
    logic             hunt_ok;
    logic [IDX_W-1:0] hunt_idx;
    logic [IDX_W-1:0] up_i;
    logic [IDX_W-1:0] right_i;
    logic [IDX_W-1:0] down_i;
    logic [IDX_W-1:0] left_i;
    int               row;
    int               col;

    // After a hit, try the unshot orthogonal neighbours in order up, right, down, left.
    always_comb begin
        row      = int'(last_idx) / BOARD_N;
        col      = int'(last_idx) % BOARD_N;
        up_i     = last_idx - IDX_W'(BOARD_N);
        right_i  = last_idx + IDX_W'(1);
        down_i   = last_idx + IDX_W'(BOARD_N);
        left_i   = last_idx - IDX_W'(1);
        hunt_ok  = 1'b0;
        hunt_idx = '0;
        if (row > 0 && !shot_map[up_i]) begin
            hunt_ok  = 1'b1;
            hunt_idx = up_i;
        end else if (col < BOARD_N - 1 && !shot_map[right_i]) begin
            hunt_ok  = 1'b1;
            hunt_idx = right_i;
        end else if (row < BOARD_N - 1 && !shot_map[down_i]) begin
            hunt_ok  = 1'b1;
            hunt_idx = down_i;
        end else if (col > 0 && !shot_map[left_i]) begin
            hunt_ok  = 1'b1;
            hunt_idx = left_i;
        end
    end

    assign pick_cand = (hunt && hunt_ok) ? hunt_idx : lfsr_cand;
`else
    assign pick_cand = lfsr_cand;
`endif

    // Turn sequencer; setup overrides everything and reloads the fleet.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pc_has_move <= 1'b0;
            shot_map    <= '0;
            hit_map     <= '0;
            occ         <= '0;
            last_idx    <= '0;
            last_hit    <= 1'b0;
            remaining   <= '0;
            loaded      <= 1'b0;
            cnt         <= '0;
            cand        <= '0;
`ifdef PC_HUNT_EN
            hunt        <= 1'b0;
`endif
        end else if (setup_State) begin
            occ         <= player_board;
            shot_map    <= '0;
            hit_map     <= '0;
            remaining   <= (IDX_W+1)'($countones(player_board));
            loaded      <= 1'b1;
            state       <= IDLE;
            pc_has_move <= 1'b0;
`ifdef PC_HUNT_EN
            hunt        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pc_turn_State) begin
                        state <= THINK;
                        cnt   <= '0;
                    end
                end
                THINK: begin
                    if (!pc_turn_State) begin
                        state <= IDLE;
                    end else if (cnt == CNT_W'(THINK_CYCLES - 1)) begin
                        state <= PICK;
                        cand  <= pick_cand;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PICK: begin
                    if (!pc_turn_State) begin
                        state <= IDLE;
                    end else if (&shot_map) begin
                        state       <= DONE;
                        pc_has_move <= 1'b1;
                    end else if (!shot_map[cand]) begin
                        state <= FIRE;
                    end else begin
                        cand <= (cand == IDX_W'(CELLS - 1)) ? '0 : cand + IDX_W'(1);
                    end
                end
                FIRE: begin
                    shot_map[cand] <= 1'b1;
                    last_idx       <= cand;
                    last_hit       <= occ[cand];
                    if (occ[cand]) begin
                        hit_map[cand] <= 1'b1;
                        if (remaining != '0)
                            remaining <= remaining - (IDX_W+1)'(1);
                    end
`ifdef PC_HUNT_EN
                    hunt           <= occ[cand];
`endif
                    state          <= DONE;
                    pc_has_move    <= 1'b1;
                end
                DONE: begin
                    if (!pc_turn_State) begin
                        state       <= IDLE;
                        pc_has_move <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_shot_engine.sv
// Self-checking bench for pc_shot_engine: randomized boards and turn gaps scored against
// a behavioural model of the board, the LFSR sequence and the turn latency.
module tb_pc_shot_engine;

    localparam int T     = 4;
    localparam int N     = 5;
    localparam int CELLS = N * N;

    logic        clk = 1'b0;
    logic        rst;
    logic        setup_State;
    logic        pc_turn_State;
    logic [24:0] player_board;
    logic        pc_has_move;
    logic        player_ships_zero;
    logic [24:0] shot_map;
    logic [24:0] hit_map;
    logic [4:0]  last_idx;
    logic        last_hit;

    logic [24:0] m_occ;
    logic [24:0] m_shot;
    logic [24:0] m_hit;
    int          m_rem;
    bit          m_loaded;
    int          m_last_idx;
    bit          m_last_hit;
    bit          m_hunt;
    logic [7:0]  m_lfsr;

    int checks   = 0;
    int failures = 0;

    pc_shot_engine #(.BOARD_N(N), .THINK_CYCLES(T), .LFSR_SEED(8'hA5)) dut (
        .clk               (clk),
        .rst               (rst),
        .setup_State       (setup_State),
        .pc_turn_State     (pc_turn_State),
        .player_board      (player_board),
        .pc_has_move       (pc_has_move),
        .player_ships_zero (player_ships_zero),
        .shot_map          (shot_map),
        .hit_map           (hit_map),
        .last_idx          (last_idx),
        .last_hit          (last_hit)
    );

    always #5 clk = ~clk;

    // Reference pseudo-random sequence: polynomial x^8+x^6+x^5+x^4+1, seed A5.
    always @(posedge clk or negedge rst) begin
        if (!rst)
            m_lfsr <= 8'hA5;
        else
            m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkBoard(input string tag);
        checkOutput({tag, ".shot_map"}, 32'(shot_map), 32'(m_shot));
        checkOutput({tag, ".hit_map"}, 32'(hit_map), 32'(m_hit));
        checkOutput({tag, ".last_idx"}, 32'(last_idx), 32'(m_last_idx));
        checkOutput({tag, ".last_hit"}, 32'(last_hit), 32'(m_last_hit));
        checkOutput({tag, ".ships_zero"}, 32'(player_ships_zero), 32'(m_loaded && m_rem == 0));
    endtask

    function automatic int modelCand(input logic [7:0] l);
        int base;
        base = int'(l) % CELLS;
`ifdef PC_HUNT_EN
        if (m_hunt) begin
            int r;
            int c;
            r = m_last_idx / N;
            c = m_last_idx % N;
            if (r > 0 && !m_shot[m_last_idx - N]) return m_last_idx - N;
            if (c < N - 1 && !m_shot[m_last_idx + 1]) return m_last_idx + 1;
            if (r < N - 1 && !m_shot[m_last_idx + N]) return m_last_idx + N;
            if (c > 0 && !m_shot[m_last_idx - 1]) return m_last_idx - 1;
        end
`endif
        return base;
    endfunction

    task automatic doSetup(input logic [24:0] board);
        player_board = board;
        setup_State  = 1'b1;
        @(negedge clk);
        setup_State  = 1'b0;
        m_occ        = board;
        m_shot       = '0;
        m_hit        = '0;
        m_rem        = $countones(board);
        m_loaded     = 1'b1;
        m_hunt       = 1'b0;
    endtask

    // One full PC turn: raise pc_turn_State, wait for the shot, score it, release.
    task automatic applyStimulus(input string tag);
        int         edges;
        int         lat_exp;
        int         c;
        int         probes;
        bit         got;
        bit         all_shot;
        logic [7:0] pre;
        logic [7:0] pick_l;
        edges    = 0;
        got      = 1'b0;
        pick_l   = 8'h00;
        all_shot = (m_shot == 25'h1FF_FFFF);
        pc_turn_State = 1'b1;
        while (!got && edges < 200) begin
            pre = m_lfsr;
            @(posedge clk);
            edges++;
            if (edges == 1 + T) pick_l = pre;
            @(negedge clk);
            if (pc_has_move) got = 1'b1;
        end
        checkOutput({tag, ".got_move"}, 32'(got), 32'd1);
        if (all_shot) begin
            lat_exp = T + 2;
        end else begin
            c      = modelCand(pick_l);
            probes = 0;
            while (m_shot[c]) begin
                c = (c + 1) % CELLS;
                probes++;
            end
            lat_exp    = 1 + T + probes + 2;
            m_shot[c]  = 1'b1;
            m_last_idx = c;
            m_last_hit = m_occ[c];
            m_hunt     = m_occ[c];
            if (m_occ[c]) begin
                m_hit[c] = 1'b1;
                if (m_rem > 0) m_rem--;
            end
        end
        checkOutput({tag, ".latency"}, 32'(edges), 32'(lat_exp));
        checkBoard(tag);
        repeat (2) @(negedge clk);
        checkOutput({tag, ".move_held"}, 32'(pc_has_move), 32'd1);
        pc_turn_State = 1'b0;
        @(negedge clk);
        checkOutput({tag, ".move_released"}, 32'(pc_has_move), 32'd0);
        repeat ($urandom_range(0, 5)) @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog simulation time exceeded");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst           = 1'b0;
        setup_State   = 1'b0;
        pc_turn_State = 1'b0;
        player_board  = '0;
        m_occ = '0; m_shot = '0; m_hit = '0; m_rem = 0; m_loaded = 1'b0;
        m_last_idx = 0; m_last_hit = 1'b0; m_hunt = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("reset.has_move", 32'(pc_has_move), 32'd0);
        checkBoard("reset");

        doSetup(25'h0000007);
        checkBoard("setup3");
        applyStimulus("first_turn");

        // Asynchronous reset in the middle of THINK clears everything and reseeds the LFSR.
        pc_turn_State = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        m_occ = '0; m_shot = '0; m_hit = '0; m_rem = 0; m_loaded = 1'b0;
        m_last_idx = 0; m_last_hit = 1'b0; m_hunt = 1'b0;
        checkOutput("midreset.has_move", 32'(pc_has_move), 32'd0);
        checkBoard("midreset");
        pc_turn_State = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        doSetup(25'h0000007);
        checkBoard("setup3b");

        // Dropping pc_turn_State during THINK must abort without firing.
        pc_turn_State = 1'b1;
        repeat (2) @(negedge clk);
        pc_turn_State = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("abort.has_move", 32'(pc_has_move), 32'd0);
        checkBoard("abort");

        for (int i = 0; i < CELLS; i++) applyStimulus($sformatf("fill%0d", i));
        checkOutput("fill.all_shot", 32'(shot_map), 32'h01FF_FFFF);
        applyStimulus("full_board");

        doSetup(25'h0000001);
        checkBoard("single");
        for (int i = 0; i < CELLS && !m_shot[0]; i++) applyStimulus($sformatf("single%0d", i));
        checkOutput("single.hit0", 32'(hit_map[0]), 32'd1);
        checkOutput("single.ships_zero", 32'(player_ships_zero), 32'd1);

        for (int r = 0; r < 3; r++) begin
            doSetup(25'($urandom));
            checkBoard($sformatf("rand_setup%0d", r));
            for (int i = 0; i < 6; i++) applyStimulus($sformatf("rand%0d_%0d", r, i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
